// File: rtl/cl_ddr_loader_pkg.sv
// Shared types and constants for the DDR word loader.
//   ldr_state_t      : loader control states
//   BEAT_BYTES       : bytes per 512-bit AXI beat
//   WORDS_PER_BEAT   : 32-bit words per beat
//   AXI_RESP_OKAY    : OKAY response encoding
//   bytes_to_4k()    : bytes from an address to the next 4 KB boundary
package cl_ddr_loader_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} ldr_state_t;

  localparam int         BEAT_BYTES     = 64;
  localparam int         WORDS_PER_BEAT = 16;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Only the low 12 address bits matter; result is 1..4096.
  function automatic logic [12:0] bytes_to_4k(input logic [11:0] addr_lo);
    return 13'd4096 - {1'b0, addr_lo};
  endfunction
endpackage

// File: rtl/cl_ddr_word_loader_unpacker.sv
// beat_word_unpacker: holds one 512-bit beat and emits its words, lowest
// first, over a valid/ready stream.
//   clk_i, rst_ni       : clock, async active-low reset
//   load_i, data_i      : load a beat (only legal while empty_o)
//   valid_words_i       : how many words of the beat to emit (1..16)
//   last_i              : this beat is the final one of the load
//   out_data_o/valid_o/ready_i/last_o : word stream
//   empty_o             : nothing left to emit
//   drained_o           : the beat's final word is accepted this cycle
module beat_word_unpacker
  import cl_ddr_loader_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [511:0] data_i,
  input  logic [4:0]   valid_words_i,
  input  logic         last_i,
  output logic [31:0]  out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         out_last_o,
  output logic         empty_o,
  output logic         drained_o
);
  logic [511:0] sr_q;
  logic [4:0]   rem_q;
  logic         vld_q, fin_q, last_q;
  logic         take;

  assign take        = vld_q && out_ready_i;
  assign out_data_o  = sr_q[31:0];
  assign out_valid_o = vld_q;
  assign out_last_o  = last_q;
  assign empty_o     = !vld_q;
  assign drained_o   = take && (rem_q == 5'd1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q   <= '0;
      rem_q  <= '0;
      vld_q  <= 1'b0;
      fin_q  <= 1'b0;
      last_q <= 1'b0;
    end else if (load_i) begin
      sr_q   <= data_i;
      rem_q  <= valid_words_i;
      vld_q  <= (valid_words_i != 5'd0);
      fin_q  <= last_i;
      last_q <= last_i && (valid_words_i == 5'd1);
    end else if (take) begin
      sr_q   <= sr_q >> 32;
      rem_q  <= rem_q - 5'd1;
      vld_q  <= (rem_q != 5'd1);
      // out_last rides with the word that will be left after this take
      last_q <= fin_q && (rem_q == 5'd2);
    end
  end
endmodule

// File: rtl/cl_ddr_word_loader.sv
// cl_ddr_word_loader: on a start rising edge, reads word_count 32-bit words
// from DDR at base_addr (AXI4 INCR, 64 B beats, one burst in flight, bursts
// split at MAX_BURST and 4 KB) and streams them out in address order.
//   clk_main_a0, rst_main_n : clock, async active-low reset
//   start, base_addr, word_count : load request
//   ar*, r*  : AXI4 read master
//   out_*    : word stream, out_last on the final word
//   busy, done, error : status (error sticky until next start)
module cl_ddr_word_loader
  import cl_ddr_loader_pkg::*;
#(
  parameter int              ID_W      = 16,
  parameter int              MAX_BURST = 8,
  parameter logic [ID_W-1:0] AXI_ID    = '0
) (
  input  logic            clk_main_a0,
  input  logic            rst_main_n,
  input  logic            start,
  input  logic [63:0]     base_addr,
  input  logic [31:0]     word_count,
  output logic [ID_W-1:0] arid,
  output logic [63:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [511:0]    rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [31:0]     out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            busy,
  output logic            done,
  output logic            error
);
  ldr_state_t  state_q, state_d;
  logic        start_q, start_qq;
  logic [63:0] araddr_q;
  logic [7:0]  arlen_q;
  logic        arvalid_q, rready_q, rready_d;
  logic [31:0] beats_left_q, rx_left_q;
  logic [3:0]  tail_q;
  logic        last_seen_q, last_seen_d;
  logic        busy_q, done_q, error_q;

  logic        start_load, ar_hs, r_hs, burst_end, enter_req, final_beat;
  logic [31:0] total_beats, burst_beats, req_beats, req_len, beats_4k;
  logic [63:0] req_addr;
  logic [4:0]  valid_words;
  logic        u_empty, u_drained;
  logic        unused_rid;

  assign unused_rid = ^rid;

  assign arid    = AXI_ID;
  assign arsize  = 3'd6;
  assign arburst = AXI_BURST_INCR;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;

  assign start_load  = start_q && !start_qq && (state_q == IDLE || state_q == DONE);
  assign ar_hs       = arvalid_q && arready;
  assign r_hs        = rvalid && rready_q;
  assign burst_end   = (state_q == DATA) && last_seen_q && u_drained;
  assign total_beats = {4'd0, word_count[31:4]} + {31'd0, |word_count[3:0]};
  assign burst_beats = {24'd0, arlen_q} + 32'd1;
  assign final_beat  = (rx_left_q == 32'd1);
  // Only the final beat is trimmed to the remainder; 0 remainder means full.
  assign valid_words = (final_beat && tail_q != 4'd0) ? {1'b0, tail_q} : 5'(WORDS_PER_BEAT);

  always_comb begin
    state_d   = state_q;
    enter_req = 1'b0;
    req_addr  = araddr_q;
    req_beats = beats_left_q;
    case (state_q)
      IDLE, DONE: if (start_load) begin
        req_addr  = base_addr;
        req_beats = total_beats;
        if (word_count == 32'd0) state_d = DONE;
        else begin state_d = REQ; enter_req = 1'b1; end
      end
      REQ:  if (ar_hs) state_d = DATA;
      DATA: if (burst_end) begin
        req_addr  = araddr_q + 64'(burst_beats) * 64'(BEAT_BYTES);
        req_beats = beats_left_q - burst_beats;
        if (req_beats == 32'd0) state_d = DONE;
        else begin state_d = REQ; enter_req = 1'b1; end
      end
      default: state_d = IDLE;
    endcase

    beats_4k = 32'(bytes_to_4k(req_addr[11:0])) / 32'(BEAT_BYTES);
    req_len  = req_beats;
    if (req_len > 32'(MAX_BURST)) req_len = 32'(MAX_BURST);
    if (req_len > beats_4k)       req_len = beats_4k;

    last_seen_d = last_seen_q;
    if (ar_hs)               last_seen_d = 1'b0;
    else if (r_hs && rlast)  last_seen_d = 1'b1;

    // Accept a beat only into an empty unpacker; reopen the same cycle the
    // previous beat's last word leaves so the next beat is not delayed.
    rready_d = (state_d == DATA) && !last_seen_d && ((u_empty && !r_hs) || u_drained);
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      start_qq     <= 1'b0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      beats_left_q <= '0;
      rx_left_q    <= '0;
      tail_q       <= '0;
      last_seen_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      start_qq    <= start_q;
      rready_q    <= rready_d;
      last_seen_q <= last_seen_d;
      busy_q      <= (state_d == REQ) || (state_d == DATA);
      done_q      <= (state_d == DONE);
      if (enter_req) begin
        araddr_q     <= req_addr;
        arlen_q      <= 8'(req_len - 32'd1);
        arvalid_q    <= 1'b1;
        beats_left_q <= req_beats;
      end else if (ar_hs) begin
        arvalid_q <= 1'b0;
      end
      if (start_load) begin
        rx_left_q <= total_beats;
        tail_q    <= word_count[3:0];
      end else if (r_hs) begin
        rx_left_q <= rx_left_q - 32'd1;
      end
      if (start_load)                          error_q <= 1'b0;
      else if (r_hs && rresp != AXI_RESP_OKAY) error_q <= 1'b1;
    end
  end

  beat_word_unpacker u_unpack (
    .clk_i        (clk_main_a0),
    .rst_ni       (rst_main_n),
    .load_i       (r_hs),
    .data_i       (rdata),
    .valid_words_i(valid_words),
    .last_i       (final_beat),
    .out_data_o   (out_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_last_o   (out_last),
    .empty_o      (u_empty),
    .drained_o    (u_drained)
  );
endmodule
